// File: rtl/obi_slave_cut_pkg.sv
// OBI request/response bundles shared by the registered slave cut and its users.
package obi_slave_cut_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_slave_cut.sv
// Registered OBI cut: one-entry request register and a registered response path.
// It bounds in-flight transactions, reports bus idle and flags unsolicited responses.
module obi_slave_cut
  import obi_slave_cut_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slv_req_i,
  output obi_resp_t slv_resp_o,
  output obi_req_t  mst_req_o,
  input  obi_resp_t mst_resp_i,
  output logic      idle_o,
  output logic      err_o,
  input  logic      err_clr_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             req_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] dn_cnt;
  logic             err_q;

  logic slv_gnt;
  logic dn_hs;
  logic rsp_acc;
  logic rsp_bad;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CNT_W'(1);
      2'b01:   return cnt - CNT_W'(1);
      default: return cnt;
    endcase
  endfunction

  // The only combinational path through the cut is mst gnt -> slv gnt.
  assign slv_gnt = rst_ni && slv_req_i.req && (!req_q || mst_resp_i.gnt) && (up_cnt < MAX_CNT);
  assign dn_hs   = req_q && mst_resp_i.gnt;
  assign rsp_acc = mst_resp_i.rvalid && (dn_cnt != '0);
  assign rsp_bad = mst_resp_i.rvalid && (dn_cnt == '0);

  // Request stage: fields stay put while the downstream grant is withheld.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (slv_gnt) begin
      req_q   <= 1'b1;
      we_q    <= slv_req_i.we;
      be_q    <= slv_req_i.be;
      addr_q  <= slv_req_i.addr;
      wdata_q <= slv_req_i.wdata;
    end else if (dn_hs) begin
      req_q   <= 1'b0;
    end
  end

  // Response stage: unsolicited responses are dropped here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rsp_acc;
      if (rsp_acc) rdata_q <= mst_resp_i.rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_cnt <= '0;
      dn_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      up_cnt <= cnt_step(up_cnt, slv_gnt, rvalid_q);
      dn_cnt <= cnt_step(dn_cnt, dn_hs, rsp_acc);
      if (rsp_bad)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  always_comb begin
    slv_resp_o        = '0;
    slv_resp_o.gnt    = slv_gnt;
    slv_resp_o.rvalid = rvalid_q;
    slv_resp_o.rdata  = rdata_q;
  end

  always_comb begin
    mst_req_o       = '0;
    mst_req_o.req   = req_q;
    mst_req_o.we    = we_q;
    mst_req_o.be    = be_q;
    mst_req_o.addr  = addr_q;
    mst_req_o.wdata = wdata_q;
  end

  assign idle_o = !req_q && (up_cnt == '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_obi_slave_cut.sv
// Bench for obi_slave_cut: directed scenarios plus randomized traffic against a transaction-level model.
module tb_obi_slave_cut;
  import obi_slave_cut_pkg::*;

  logic      clk;
  logic      rst_n;
  obi_req_t  sreq, mreq, sreq3, mreq3;
  obi_resp_t sresp, mresp, sresp3, mresp3;
  logic      idle, err, err_clr, idle3, err3, err_clr3;

  int n_chk = 0;
  int n_fail = 0;

  obi_slave_cut #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(sreq), .slv_resp_o(sresp),
    .mst_req_o(mreq), .mst_resp_i(mresp), .idle_o(idle), .err_o(err), .err_clr_i(err_clr));

  obi_slave_cut #(.MAX_OUTSTANDING(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(sreq3), .slv_resp_o(sresp3),
    .mst_req_o(mreq3), .mst_resp_i(mresp3), .idle_o(idle3), .err_o(err3), .err_clr_i(err_clr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Transaction-level reference for the MAX_OUTSTANDING=2 instance:
  // "issued" is the list of downstream transactions still waiting for data,
  // "pending" counts upstream-accepted transactions not yet answered upstream.
  bit       m_held;
  obi_req_t m_fields;
  int       m_pending;
  int       m_issued;
  bit       m_rv;
  logic [31:0] m_rdata;
  bit       m_err;
  logic     m_gnt;

  assign m_gnt = rst_n && sreq.req && (!m_held || mresp.gnt) && (m_pending < 2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held <= 0; m_fields <= '0; m_pending <= 0; m_issued <= 0;
      m_rv <= 0; m_rdata <= '0; m_err <= 0;
    end else begin
      m_pending <= m_pending + (m_gnt ? 1 : 0) - (m_rv ? 1 : 0);
      m_issued  <= m_issued + ((m_held && mresp.gnt) ? 1 : 0)
                 - ((mresp.rvalid && m_issued > 0) ? 1 : 0);
      m_rv <= mresp.rvalid && (m_issued > 0);
      if (mresp.rvalid && m_issued > 0) m_rdata <= mresp.rdata;
      if (mresp.rvalid && m_issued == 0) m_err <= 1;
      else if (err_clr) m_err <= 0;
      if (m_gnt) begin
        m_held <= 1; m_fields <= sreq;
      end else if (m_held && mresp.gnt) begin
        m_held <= 0;
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    sreq = '0; sreq.req = 1'b1; sreq.addr = $urandom;
    mresp = '0; mresp.gnt = 1'b1;
    #1;
    n_chk++; if (sresp.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b required 0", sresp.gnt); end
    n_chk++; if (mreq !== '0) begin n_fail++; $display("FAIL reset_mreq: got %h required 0", mreq); end
    n_chk++; if (sresp.rvalid !== 1'b0 || sresp.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp: got rvalid %b rdata %h required 0/0", sresp.rvalid, sresp.rdata); end
    n_chk++; if (idle !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL reset_idle_err: got idle %b err %b required 1/0", idle, err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sreq = '0; mresp = '0;
  endtask

  task automatic test_single_read;
    @(negedge clk);
    sreq = '0; sreq.req = 1'b1; sreq.addr = 32'h0000_1000;
    mresp = '0; mresp.gnt = 1'b1;
    #1;
    n_chk++; if (sresp.gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt_T: got %b required 1", sresp.gnt); end
    n_chk++; if (mreq.req !== 1'b0) begin n_fail++; $display("FAIL rd_mreq_T: got %b required 0", mreq.req); end
    @(negedge clk);
    sreq.req = 1'b0;
    #1;
    n_chk++; if (mreq.req !== 1'b1 || mreq.addr !== 32'h0000_1000 || mreq.we !== 1'b0) begin n_fail++; $display("FAIL rd_mreq_T1: got req %b addr %h we %b required 1 00001000 0", mreq.req, mreq.addr, mreq.we); end
    @(negedge clk);
    mresp.rvalid = 1'b1; mresp.rdata = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (mreq.req !== 1'b0 || sresp.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_T2: got mreq %b rvalid %b required 0/0", mreq.req, sresp.rvalid); end
    @(negedge clk);
    mresp.rvalid = 1'b0;
    #1;
    n_chk++; if (sresp.rvalid !== 1'b1 || sresp.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rvalid_T3: got %b %h required 1 deadbeef", sresp.rvalid, sresp.rdata); end
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rd_idle_T3: got %b required 0", idle); end
    @(negedge clk);
    #1;
    n_chk++; if (idle !== 1'b1 || sresp.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_idle_T4: got idle %b rvalid %b required 1/0", idle, sresp.rvalid); end
  endtask

  task automatic test_write_stall;
    obi_req_t exp;
    int dn_hs;
    dn_hs = 0;
    @(negedge clk);
    sreq = '0; sreq.req = 1'b1; sreq.we = 1'b1; sreq.be = 4'b0011;
    sreq.addr = 32'h0000_2000; sreq.wdata = 32'h1234_5678;
    mresp = '0;
    exp = sreq;
    #1;
    n_chk++; if (sresp.gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b required 1", sresp.gnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sreq.req = (k < 3); sreq.wdata = $urandom; sreq.addr = $urandom;
      mresp.gnt = (k == 3);
      #1;
      n_chk++; if (mreq !== exp) begin n_fail++; $display("FAIL wr_stable_%0d: got %h required %h", k, mreq, exp); end
      if (k < 3) begin
        n_chk++; if (sresp.gnt !== 1'b0) begin n_fail++; $display("FAIL wr_no_gnt_%0d: got %b required 0", k, sresp.gnt); end
      end
      if (mreq.req && mresp.gnt) dn_hs++;
    end
    @(negedge clk);
    sreq.req = 1'b0;
    mresp.gnt = 1'b1; mresp.rvalid = 1'b1; mresp.rdata = 32'h0;
    #1;
    if (mreq.req && mresp.gnt) dn_hs++;
    n_chk++; if (dn_hs !== 1) begin n_fail++; $display("FAIL wr_dn_handshakes: got %0d required 1", dn_hs); end
    @(negedge clk);
    mresp = '0;
    #1;
    n_chk++; if (sresp.rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid: got %b required 1", sresp.rvalid); end
    @(negedge clk);
    #1;
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wr_idle: got %b required 1", idle); end
  endtask

  task automatic test_outstanding;
    int sched[$];
    int pre_grants, grants, rvs, occ, max_occ;
    bit seen_rv;
    pre_grants = 0; grants = 0; rvs = 0; occ = 0; max_occ = 0; seen_rv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      sreq = '0; sreq.req = (cyc < 12); sreq.addr = $urandom;
      mresp = '0; mresp.gnt = 1'b1;
      if (sched.size() > 0 && sched[0] == cyc) begin
        mresp.rvalid = 1'b1; mresp.rdata = $urandom;
        void'(sched.pop_front());
      end
      #1;
      if (sresp.rvalid) begin seen_rv = 1; rvs++; occ--; end
      if (sresp.gnt) begin
        grants++; occ++;
        if (!seen_rv) pre_grants++;
      end
      if (occ > max_occ) max_occ = occ;
      if (mreq.req && mresp.gnt) sched.push_back(cyc + 5);
    end
    n_chk++; if (pre_grants !== 2) begin n_fail++; $display("FAIL out_pre_grants: got %0d required 2", pre_grants); end
    n_chk++; if (max_occ !== 2) begin n_fail++; $display("FAIL out_max_inflight: got %0d required 2", max_occ); end
    n_chk++; if (grants !== rvs || sched.size() != 0) begin n_fail++; $display("FAIL out_drain: got grants %0d rvalids %0d left %0d required equal, 0 left", grants, rvs, sched.size()); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL out_idle: got %b required 1", idle); end
  endtask

  task automatic test_spurious;
    @(negedge clk);
    sreq = '0; mresp = '0; err_clr = 1'b0;
    mresp.rvalid = 1'b1; mresp.rdata = 32'hCAFE_0000;
    @(negedge clk);
    mresp = '0;
    #1;
    n_chk++; if (sresp.rvalid !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL spur_set: got rvalid %b err %b required 0/1", sresp.rvalid, err); end
    @(negedge clk);
    #1;
    n_chk++; if (sresp.rvalid !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got rvalid %b err %b required 0/1", sresp.rvalid, err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %b required 0", err); end
    mresp.rvalid = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    mresp = '0; err_clr = 1'b0;
    #1;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_set_wins: got %b required 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear2: got %b required 0", err); end
  endtask

  task automatic test_back_to_back;
    bit exp_rv;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sreq3 = '0; sreq3.req = (c < 3); sreq3.addr = 32'h100 + 32'(c * 4);
      mresp3 = '0; mresp3.gnt = 1'b1;
      if (c >= 2 && c <= 4) begin mresp3.rvalid = 1'b1; mresp3.rdata = 32'(c - 1); end
      #1;
      if (c < 3) begin
        n_chk++; if (sresp3.gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_%0d: got %b required 1", c, sresp3.gnt); end
      end
      exp_rv = (c >= 3 && c <= 5);
      n_chk++; if (sresp3.rvalid !== exp_rv) begin n_fail++; $display("FAIL b2b_rvalid_%0d: got %b required %b", c, sresp3.rvalid, exp_rv); end
      if (exp_rv) begin
        n_chk++; if (sresp3.rdata !== 32'(c - 2)) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h required %h", c, sresp3.rdata, 32'(c - 2)); end
      end
    end
    n_chk++; if (idle3 !== 1'b1 || err3 !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got idle %b err %b required 1/0", idle3, err3); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    sreq = '0; sreq.req = 1'b1; sreq.addr = 32'h3000;
    mresp = '0; mresp.gnt = 1'b1; mresp.rvalid = 1'b1;
    @(negedge clk);
    sreq.addr = 32'h3004; mresp.rvalid = 1'b0;
    @(negedge clk);
    sreq.req = 1'b0; mresp.gnt = 1'b0;
    #1;
    n_chk++; if (mreq.req !== 1'b1 || err !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL rst_pre: got req %b err %b idle %b required 1/1/0", mreq.req, err, idle); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (mreq.req !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL rst_now: got req %b idle %b err %b required 0/1/0", mreq.req, idle, err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mresp.rvalid = 1'b1; mresp.rdata = $urandom;
    @(negedge clk);
    mresp.rvalid = 1'b0;
    #1;
    n_chk++; if (sresp.rvalid !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL rst_stale: got rvalid %b err %b required 0/1", sresp.rvalid, err); end
    @(negedge clk);
    #1;
    n_chk++; if (sresp.rvalid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rst_after: got rvalid %b idle %b required 0/1", sresp.rvalid, idle); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_random;
    obi_req_t exp;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      sreq.req = ($urandom_range(0, 3) != 0);
      sreq.we = 1'($urandom); sreq.be = 4'($urandom);
      sreq.addr = $urandom; sreq.wdata = $urandom;
      mresp.gnt = 1'($urandom);
      mresp.rvalid = (m_issued > 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
      mresp.rdata = $urandom;
      err_clr = ($urandom_range(0, 9) == 0);
      #1;
      exp = m_fields; exp.req = m_held;
      n_chk++; if (sresp.gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b required %b", c, sresp.gnt, m_gnt); end
      n_chk++; if (mreq !== exp) begin n_fail++; $display("FAIL rnd_mreq@%0d: got %h required %h", c, mreq, exp); end
      n_chk++; if (sresp.rvalid !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b required %b", c, sresp.rvalid, m_rv); end
      if (m_rv) begin
        n_chk++; if (sresp.rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h required %h", c, sresp.rdata, m_rdata); end
      end
      n_chk++; if (idle !== (!m_held && m_pending == 0)) begin n_fail++; $display("FAIL rnd_idle@%0d: got %b required %b", c, idle, (!m_held && m_pending == 0)); end
      n_chk++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b required %b", c, err, m_err); end
      n_chk++; if (m_pending > 2) begin n_fail++; $display("FAIL rnd_bound@%0d: got %0d required <=2", c, m_pending); end
    end
    @(negedge clk);
    sreq = '0; mresp = '0; err_clr = 1'b0;
  endtask

  initial begin
    sreq = '0; mresp = '0; err_clr = 1'b0;
    sreq3 = '0; mresp3 = '0; err_clr3 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_write_stall();
    test_outstanding();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
